// File: rtl/red_pitaya_rst_seq.sv
// Reset sequencer behind the board PLL: pulses the PLL reset, debounces lock,
// releases ADC -> DAC -> system resets in order, and re-sequences on lock loss or relock.
module red_pitaya_rst_seq #(
    parameter int unsigned LCK_DLY     = 1024,
    parameter int unsigned LCK_TMO     = 65536,
    parameter int unsigned STG_DLY     = 16,
    parameter int unsigned PLL_RST_LEN = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_locked,
    input  logic       relock,
    output logic       pll_rstn,
    output logic       rst_adc_n,
    output logic       rst_dac_n,
    output logic       rst_sys_n,
    output logic       locked_ok,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_REL_ADC   = 3'd2,
        S_REL_DAC   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // One timer serves the PLL pulse, the stage delays and the lock timeout.
    localparam int unsigned MAX_A   = (LCK_TMO > STG_DLY) ? LCK_TMO : STG_DLY;
    localparam int unsigned TMR_MAX = (MAX_A > PLL_RST_LEN) ? MAX_A : PLL_RST_LEN;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned STB_W   = $clog2(LCK_DLY + 1);

    localparam logic [TMR_W-1:0] PLL_LAST = TMR_W'(PLL_RST_LEN - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LCK_TMO - 1);
    localparam logic [TMR_W-1:0] STG_LAST = TMR_W'(STG_DLY - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LCK_DLY - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [STB_W-1:0] stb_q, stb_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, lock_s_q;
    logic             pll_rstn_q, adc_q, dac_q, sys_q, ok_q;
    logic             pll_rstn_d, adc_d, dac_d, sys_d, ok_d;
    logic             lost;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_PLL_RST;
            tmr_q      <= '0;
            stb_q      <= '0;
            loss_q     <= '0;
            pll_rstn_q <= 1'b0;
            adc_q      <= 1'b0;
            dac_q      <= 1'b0;
            sys_q      <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            stb_q      <= stb_d;
            loss_q     <= loss_d;
            pll_rstn_q <= pll_rstn_d;
            adc_q      <= adc_d;
            dac_q      <= dac_d;
            sys_q      <= sys_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        stb_d   = stb_q;
        loss_d  = loss_q;
        lost    = !lock_s_q && (state_q inside {S_REL_ADC, S_REL_DAC, S_RUN});

        case (state_q)
            S_PLL_RST: begin
                if (tmr_q == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                    tmr_d   = '0;
                    stb_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                stb_d = lock_s_q ? stb_q + STB_W'(1) : '0;
                tmr_d = tmr_q + TMR_W'(1);
                if (lock_s_q && stb_q == STB_LAST) begin
                    state_d = S_REL_ADC;
                    tmr_d   = '0;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = S_PLL_RST;
                    tmr_d   = '0;
                end
            end
            S_REL_ADC: begin
                if (tmr_q == STG_LAST) begin
                    state_d = S_REL_DAC;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_REL_DAC: begin
                if (tmr_q == STG_LAST) begin
                    state_d = S_RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_RUN: begin
                tmr_d = '0;
            end
            default: begin
                state_d = S_PLL_RST;
                tmr_d   = '0;
                stb_d   = '0;
            end
        endcase

        // Loss keeps the PLL running; relock overrides it but the loss is still counted.
        if (lost) begin
            state_d = S_WAIT_LOCK;
            tmr_d   = '0;
            stb_d   = '0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end
        if (relock && state_q != S_PLL_RST) begin
            state_d = S_PLL_RST;
            tmr_d   = '0;
            stb_d   = '0;
        end
    end

    always_comb begin
        pll_rstn_d = (state_d != S_PLL_RST);
        adc_d      = (state_d inside {S_REL_ADC, S_REL_DAC, S_RUN});
        dac_d      = (state_d inside {S_REL_DAC, S_RUN});
        sys_d      = (state_d == S_RUN);
        ok_d       = (state_d == S_RUN);
    end

    assign pll_rstn  = pll_rstn_q;
    assign rst_adc_n = adc_q;
    assign rst_dac_n = dac_q;
    assign rst_sys_n = sys_q;
    assign locked_ok = ok_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: doc/red_pitaya_rst_seq.md
# red_pitaya_rst_seq

Reset sequencer directly downstream of the board PLL. It runs on the PLL reference clock, so it keeps running while the PLL is unlocked. It drives the PLL reset, debounces the asynchronous PLL lock indication, and releases the ADC, DAC and system reset domains in a fixed staged order. It also re-asserts all domain resets on loss of lock and counts lock losses for the housekeeping registers.

## Interface
- LCK_DLY, 1024: consecutive synchronized-lock cycles required before the first reset release; must be ≥1.
- LCK_TMO, 65536: maximum cycles spent in WAIT_LOCK before the PLL is reset again; must be > LCK_DLY.
- STG_DLY, 16: cycles between successive domain releases; must be ≥1.
- PLL_RST_LEN, 8: length in cycles of the PLL reset pulse; must be ≥1.
- clk  in  1  PLL reference clock (125 MHz), free-running.
- rstn  in  1  reset, asynchronous, active low.
- pll_locked  in  1  PLL lock status, asynchronous to clk.
- relock  in  1  single-cycle request, synchronous to clk, that forces a PLL reset and a full re-sequence.
- pll_rstn  out  1  PLL reset, active low.
- rst_adc_n  out  1  ADC domain reset, active low.
- rst_dac_n  out  1  DAC domain reset, active low.
- rst_sys_n  out  1  system/serial domain reset, active low.
- locked_ok  out  1  high only in RUN.
- loss_cnt  out  8  saturating count of lock losses.
- state  out  3  current state: PLL_RST=0, WAIT_LOCK=1, REL_ADC=2, REL_DAC=3, RUN=4.

## Operation
- pll_locked passes through a 2-FF synchronizer to produce lock_s. No other logic samples pll_locked.
- All outputs are registered.
- Reset values, applied asynchronously while rstn=0:
  - pll_rstn=0, rst_adc_n=0, rst_dac_n=0, rst_sys_n=0, locked_ok=0.
  - loss_cnt=0, state=PLL_RST, all counters 0.
- PLL_RST:
  - pll_rstn=0 and all domain resets asserted.
  - After PLL_RST_LEN cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rstn=1 and all domain resets asserted.
  - The stable counter increments while lock_s=1 and clears to 0 whenever lock_s=0.
  - When the stable count reaches LCK_DLY, go to REL_ADC.
  - A separate timeout counter counts every cycle in this state. When it reaches LCK_TMO, go to PLL_RST.
  - Both counters clear on entry to WAIT_LOCK.
- REL_ADC:
  - rst_adc_n=1.
  - After STG_DLY cycles, go to REL_DAC.
- REL_DAC:
  - rst_adc_n=1, rst_dac_n=1.
  - After STG_DLY cycles, go to RUN.
- RUN:
  - All domain resets released, locked_ok=1.
  - Stay in RUN until loss of lock or relock.
- Loss of lock (lock_s=0 in REL_ADC, REL_DAC or RUN):
  - All domain resets asserted and locked_ok=0 on the next edge.
  - Go to WAIT_LOCK; the PLL is not reset.
  - loss_cnt increments and saturates at 255.
  - Loss of lock is not counted in PLL_RST or WAIT_LOCK.
- relock=1 in any state other than PLL_RST: go to PLL_RST on the next edge. relock is ignored while in PLL_RST.
- Simultaneous relock and loss of lock: relock wins, state goes to PLL_RST, and loss_cnt still increments.
- Counter widths: $clog2(max(param)+1); no wrap is possible in any state.
- Output values are decoded from the next state, so outputs change on the same edge as state.

## Timing
- PLL reset pulse:
  - pll_rstn is low for exactly PLL_RST_LEN cycles after rstn deasserts.
  - pll_rstn is low for exactly PLL_RST_LEN cycles after the edge that samples relock=1.
- First release: rst_adc_n rises exactly 2+LCK_DLY edges after the first edge that samples pll_locked=1 in WAIT_LOCK, provided pll_locked stays high throughout.
- Staged releases:
  - rst_dac_n rises STG_DLY edges after rst_adc_n.
  - rst_sys_n and locked_ok rise STG_DLY edges after rst_dac_n.
- Loss-of-lock latency: resets fall and locked_ok falls 3 edges after the first edge that samples pll_locked=0 (2 synchronizer edges + 1 register edge).
- Glitch rejection: a lock_s low pulse of any length in WAIT_LOCK restarts the full LCK_DLY debounce.
- Reset mid-operation: rstn low forces reset values immediately, independent of clk. Sequencing restarts from PLL_RST on the first edge after rstn deasserts.

## Test plan
- Power-up, with LCK_DLY=16, STG_DLY=4, PLL_RST_LEN=8 and pll_locked rising 20 cycles after rstn:
  - pll_rstn low for 8 cycles.
  - rst_adc_n rises 18 edges after the first sampled lock.
  - rst_dac_n rises at +4, rst_sys_n and locked_ok at +8; state reads 4.
- Lock glitch during debounce: drop pll_locked for 1 cycle at count 10 -> release is delayed by a full 16 stable cycles after lock returns; loss_cnt stays 0.
- Loss in RUN: drop pll_locked -> all resets low and locked_ok=0 3 edges later, loss_cnt=1, state=1; pll_rstn stays 1.
- Timeout: hold pll_locked=0 with LCK_TMO=64 -> state returns to 0 after 64 WAIT_LOCK cycles and pll_rstn pulses low for 8 cycles.
- relock pulse in RUN coinciding with lock_s falling -> state=0 on the next edge, loss_cnt incremented once, full re-sequence follows.
- Loss saturation: force 300 losses -> loss_cnt stops at 255.
- rstn asserted mid-REL_DAC -> all outputs at reset values with no clk edge required.
